// File: rtl/bcd_pkg.sv
// Shared constants and FSM state encoding for the serial BCD adder.
// DIGIT_W is the width of one packed BCD digit.
package bcd_pkg;

  localparam int         DIGIT_W  = 4;
  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [3:0] BCD_CORR = 4'd6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/bcd_digit_add.sv
// Combinational single-digit BCD adder with decimal correction.
// Invalid digits (>9) go through the same rule, so the output stays deterministic.
module bcd_digit_add
  import bcd_pkg::*;
(
  input  logic [3:0] a_d,
  input  logic [3:0] b_d,
  input  logic       c,
  output logic [3:0] s,
  output logic       C
);

  logic [4:0] raw;
  logic [4:0] corrected;

  // The 5-bit raw sum cannot overflow (15 + 15 + 1 = 31).
  // Only the low nibble of the corrected value is kept.
  always_comb begin
    raw       = {1'b0, a_d} + {1'b0, b_d} + {4'b0000, c};
    corrected = raw + {1'b0, BCD_CORR};
    s         = raw[3:0];
    C         = 1'b0;
    if (raw > {1'b0, BCD_MAX}) begin
      s = corrected[3:0];
      C = 1'b1;
    end
  end

endmodule

// File: rtl/bcd_serial_adder.sv
// Multi-digit BCD adder sequencer: one digit pair per cycle, LSD first,
// with a registered carry chained between digits and a start/done handshake.
module bcd_serial_adder
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [4*DIGITS-1:0]     a,
  input  logic [4*DIGITS-1:0]     b,
  input  logic                    cin,
  output logic                    busy,
  output logic                    done,
  output logic [4*DIGITS-1:0]     sum,
  output logic                    cout,
  output logic                    err
);

  localparam int W     = DIGIT_W * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  state_t           state;
  state_t           state_next;
  logic [IDX_W-1:0] idx;
  logic [W-1:0]     a_reg;
  logic [W-1:0]     b_reg;
  logic             carry;

  logic [3:0]       a_d;
  logic [3:0]       b_d;
  logic [3:0]       s_d;
  logic             c_d;
  logic             last_digit;

  assign a_d        = a_reg[idx*DIGIT_W +: DIGIT_W];
  assign b_d        = b_reg[idx*DIGIT_W +: DIGIT_W];
  assign last_digit = (idx == LAST_IDX);

  bcd_digit_add u_digit_add (
    .a_d (a_d),
    .b_d (b_d),
    .c   (carry),
    .s   (s_d),
    .C   (c_d)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last_digit) begin
          state_next = DONE;
        end
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Operands are captured on acceptance so callers may change a/b/cin mid-run.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx   <= '0;
      a_reg <= '0;
      b_reg <= '0;
      carry <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            idx   <= '0;
            a_reg <= a;
            b_reg <= b;
            carry <= cin;
            sum   <= '0;
            cout  <= 1'b0;
            err   <= 1'b0;
          end
        end
        RUN: begin
          sum[idx*DIGIT_W +: DIGIT_W] <= s_d;
          carry <= c_d;
          err   <= err | (a_d > BCD_MAX) | (b_d > BCD_MAX);
          if (last_digit) begin
            cout <= c_d;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Self-checking bench for bcd_serial_adder: directed spec vectors plus randomized
// operands compared against a decimal-arithmetic reference model.
module tb_bcd_serial_adder;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;
  localparam int LIMIT  = 40;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         err;

  int tests_run    = 0;
  int tests_failed = 0;

  bcd_serial_adder #(.DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Valid operands use whole-number decimal addition; operands with a bad digit
  // fall back to the per-digit correction rule so the result is still defined.
  function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                input logic mcin, output logic [W-1:0] ms,
                                output logic mco, output logic me);
    int va, vb, total, c, r, da, db;
    me = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      da = int'(ma[4*i +: 4]);
      db = int'(mb[4*i +: 4]);
      if (da > 9 || db > 9) me = 1'b1;
    end
    ms = '0;
    if (!me) begin
      va = 0;
      vb = 0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
        va = va * 10 + int'(ma[4*i +: 4]);
        vb = vb * 10 + int'(mb[4*i +: 4]);
      end
      total = va + vb + int'(mcin);
      mco   = (total >= 10 ** DIGITS);
      total = total % (10 ** DIGITS);
      for (int i = 0; i < DIGITS; i++) begin
        ms[4*i +: 4] = 4'(total % 10);
        total        = total / 10;
      end
    end else begin
      c = int'(mcin);
      for (int i = 0; i < DIGITS; i++) begin
        r = int'(ma[4*i +: 4]) + int'(mb[4*i +: 4]) + c;
        if (r > 9) begin
          ms[4*i +: 4] = 4'((r + 6) % 16);
          c = 1;
        end else begin
          ms[4*i +: 4] = 4'(r);
          c = 0;
        end
      end
      mco = c[0];
    end
  endfunction

  function automatic logic [W-1:0] rand_operand(input bit allow_bad);
    logic [W-1:0] v;
    for (int i = 0; i < DIGITS; i++) begin
      if (allow_bad && $urandom_range(0, 7) == 0) v[4*i +: 4] = 4'($urandom_range(10, 15));
      else v[4*i +: 4] = 4'($urandom_range(0, 9));
    end
    return v;
  endfunction

  // Starts one operation and waits (bounded) for done; scrambles inputs after acceptance.
  task automatic run_op(input logic [W-1:0] ra, input logic [W-1:0] rb, input logic rcin,
                        output int cycles, output logic busy_seen);
    @(negedge clk);
    a     = ra;
    b     = rb;
    cin   = rcin;
    start = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    a         = W'($urandom);
    b         = W'($urandom);
    cin       = 1'($urandom);
    cycles    = 1;
    busy_seen = busy;
    while (!done && cycles < LIMIT) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b1;
    a     = 16'h1234;
    b     = 16'h5678;
    cin   = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({busy, done, sum, cout, err} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got busy=%b done=%b sum=%h cout=%b err=%b, expected all zero",
               busy, done, sum, cout, err);
    end
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_after_reset: got busy=%b done=%b, expected 0 0", busy, done);
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] va [6] = '{16'h1234, 16'h9999, 16'h0000, 16'h9999, 16'h00A0, 16'h0001};
    logic [W-1:0] vb [6] = '{16'h5678, 16'h0001, 16'h0000, 16'h9999, 16'h0001, 16'h0001};
    logic         vc [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [W-1:0] es [6] = '{16'h6912, 16'h0000, 16'h0001, 16'h9999, 16'h0000, 16'h0002};
    logic         ec [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic         ee [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    int   cycles;
    logic busy_seen;
    for (int i = 0; i < 6; i++) begin
      run_op(va[i], vb[i], vc[i], cycles, busy_seen);
      tests_run++;
      if (cycles !== DIGITS + 1 || busy_seen !== 1'b1) begin
        tests_failed++;
        $display("FAIL latency[%0d]: got %0d cycles busy=%b, expected %0d cycles busy=1",
                 i, cycles, busy_seen, DIGITS + 1);
      end
      tests_run++;
      if ((ee[i] === 1'b0 && sum !== es[i]) || cout !== ec[i] || err !== ee[i]) begin
        tests_failed++;
        $display("FAIL directed[%0d]: got sum=%h cout=%b err=%b, expected sum=%h cout=%b err=%b",
                 i, sum, cout, err, es[i], ec[i], ee[i]);
      end
      @(negedge clk);
      tests_run++;
      if (done !== 1'b0 || busy !== 1'b0 || (ee[i] === 1'b0 && sum !== es[i])) begin
        tests_failed++;
        $display("FAIL done_pulse[%0d]: got done=%b busy=%b sum=%h, expected 0 0 %h",
                 i, done, busy, sum, es[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] ra, rb, ms;
    logic rc, mc, me, busy_seen;
    int cycles;
    for (int n = 0; n < 40; n++) begin
      ra = rand_operand(n >= 30);
      rb = rand_operand(n >= 30);
      rc = 1'($urandom);
      model(ra, rb, rc, ms, mc, me);
      run_op(ra, rb, rc, cycles, busy_seen);
      tests_run++;
      if (cycles !== DIGITS + 1 || sum !== ms || cout !== mc || err !== me) begin
        tests_failed++;
        $display("FAIL random[%0d] %h+%h+%b: got sum=%h cout=%b err=%b cyc=%0d, expected sum=%h cout=%b err=%b cyc=%0d",
                 n, ra, rb, rc, sum, cout, err, cycles, ms, mc, me, DIGITS + 1);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      tests_run++;
      if (sum !== ms || cout !== mc || err !== me) begin
        tests_failed++;
        $display("FAIL hold[%0d]: got sum=%h cout=%b err=%b, expected sum=%h cout=%b err=%b",
                 n, sum, cout, err, ms, mc, me);
      end
    end
  endtask

  task automatic test_ignore_start();
    logic [W-1:0] ms;
    logic mc, me;
    int dones = 0;
    model(16'h1234, 16'h5678, 1'b0, ms, mc, me);
    @(negedge clk);
    a = 16'h1234; b = 16'h5678; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 16'h4444; b = 16'h3333; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (done) dones++;
      @(negedge clk);
    end
    tests_run++;
    if (dones !== 1 || sum !== ms || cout !== mc || err !== me) begin
      tests_failed++;
      $display("FAIL ignore_start: got dones=%0d sum=%h cout=%b err=%b, expected dones=1 sum=%h cout=%b err=%b",
               dones, sum, cout, err, ms, mc, me);
    end
  endtask

  task automatic test_abort();
    int   dones = 0;
    int   cycles;
    logic busy_seen;
    @(negedge clk);
    a = 16'h1234; b = 16'h5678; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0 || sum !== '0 || cout !== 1'b0 || err !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_state: got busy=%b done=%b sum=%h cout=%b err=%b, expected all zero",
               busy, done, sum, cout, err);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    tests_run++;
    if (dones !== 0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_no_done: got dones=%0d busy=%b, expected 0 0", dones, busy);
    end
    run_op(16'h0456, 16'h0789, 1'b1, cycles, busy_seen);
    tests_run++;
    if (cycles !== DIGITS + 1 || sum !== 16'h1246 || cout !== 1'b0 || err !== 1'b0) begin
      tests_failed++;
      $display("FAIL after_abort: got sum=%h cout=%b err=%b cyc=%0d, expected sum=1246 cout=0 err=0 cyc=%0d",
               sum, cout, err, cycles, DIGITS + 1);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] ra, rb, ms;
    logic rc, mc, me, busy_seen;
    int cycles;
    for (int n = 0; n < 6; n++) begin
      ra = rand_operand(1'b0);
      rb = rand_operand(1'b0);
      rc = 1'($urandom);
      model(ra, rb, rc, ms, mc, me);
      run_op(ra, rb, rc, cycles, busy_seen);
      tests_run++;
      if (cycles !== DIGITS + 1 || sum !== ms || cout !== mc || err !== me) begin
        tests_failed++;
        $display("FAIL back_to_back[%0d]: got sum=%h cout=%b err=%b cyc=%0d, expected sum=%h cout=%b err=%b cyc=%0d",
                 n, sum, cout, err, cycles, ms, mc, me, DIGITS + 1);
      end
    end
  endtask

  initial begin
    start = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
    rst_n = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_abort();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
